seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Receive-side monitor for multiplexed seven-segment display buses. It watches the active-low digit-enable and segment lines that drive the board display and waits for each digit's pattern to settle. It then maps each segment pattern back to its hex nibble and assembles a full multi-digit frame. It is used for on-FPGA loopback checking of the multiplier's display path and for capturing values from an external display-driving board.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits. Sets the width of an_n, value and digit_err.
- SETTLE_CYCLES, 8: consecutive identical input cycles required before a digit is sampled. Legal range is 1..2^CNT_W.
- CNT_W, 4: width of the settle counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- an_n  in  NUM_DIGITS  digit enables, active-low; at most one low in normal use.
- seg_n  in  8  segment lines, active-low.
  - bit 7 = DP; 1 means unlit.
  - bits 6:0 = inverted {g,f,e,d,c,b,a}, with segment a at bit 0.
- value  out  4*NUM_DIGITS  last published frame; digit i is in value[4i+3:4i].
- valid  out  1  single-cycle pulse when a new frame is published.
- stable  out  1  high while the last two published frames are identical and error-free.
- digit_err  out  NUM_DIGITS  per-digit invalid-pattern flags of the last published frame.

## Operation
- Active digit: an_n with exactly one bit low selects that digit's index.
  - Any other an_n value (no bit low, or several low) is blank.
  - Blank puts the block in IDLE and clears the settle counter.
- The block has three states:
  - IDLE: a single active digit moves to SETTLE with the counter at 1.
  - SETTLE: the counter increments while {index, seg_n} matches the previous cycle.
    - Any change restarts the count at 1 for the new input, or returns to IDLE if the input is blank.
    - When the count reaches SETTLE_CYCLES, the digit is captured and the state moves to HELD.
  - HELD: no further capture for this dwell. Any change of {index, seg_n} goes to SETTLE (count 1) or IDLE, by the same rules.
- Capture stores the decoded nibble and an error bit for the digit, and sets that digit's bit in the frame mask.
  - The decoded nibble is the hex value whose pattern equals ~seg_n[6:0]. The 16 legal patterns are the standard hex glyphs 0-9 and A,b,C,d,E,F.
  - A pattern that is not one of the 16 legal glyphs is an error: the error bit is set and the nibble is 0.
  - seg_n[7]=0 (DP lit) is also an error: the error bit is set and the nibble is 0.
  - Recapturing a digit before the frame completes overwrites it; the latest capture wins.
- Frame publish happens when the mask becomes all ones:
  - value and digit_err load from the capture registers.
  - valid pulses for one cycle.
  - The mask clears.
- stable is updated at every publish:
  - It goes to 1 if the new value equals the previous published value and both frames have digit_err all zero.
  - Otherwise it goes to 0.
  - It holds its level between publishes.

## Timing
- Reset values:
  - value = 0, valid = 0, stable = 0, digit_err = 0.
  - State = IDLE, mask = 0, counter = 0, previous frame = 0 with its error flag set. This set flag means the first frame after reset can never raise stable.
- Capture latency: the capture registers update on the SETTLE_CYCLES-th consecutive rising edge that sees an identical active input.
- Publish: value, digit_err, stable and valid all update on the same edge that captures the last missing digit. valid drops on the next edge.
- Back-to-back publishes are possible at most once per SETTLE_CYCLES cycles. valid never stays high for two consecutive cycles.
- Reset asserted mid-dwell or mid-frame: all state returns to reset values immediately. Partial frames are discarded.
- With SETTLE_CYCLES=1, capture happens on the first edge that sees a new active input.

## Structure
- Shared package seg7_pkg holds:
  - the 16 active-high glyph constants (7-bit, a at bit 0), identical to those used by the display encoder;
  - the DP-off constant.
- Sub-module seg7_pattern_to_hex: combinational inverse lookup.
  - Input: 7-bit active-high pattern.
  - Outputs: 4-bit nibble and a hit flag.
- The top level holds the state machine, counter, mask, capture registers and publish logic.

## Test plan
All scenarios use the default parameters; each dwell lasts 10 cycles unless stated.
- Reset: assert rst mid-dwell → all outputs 0 asynchronously; the next full frame publishes normally.
- Basic frame: an_n/seg_n = 1110/C0, 1101/F9, 1011/A4, 0111/B0 → value=16'h3210, one valid pulse, digit_err=0, stable=0.
- Stability: repeat the basic frame twice → stable=1 after the second publish. Then change digit 0 to 8'h92 ('5') → value=16'h3215, stable=0.
- Settle restart: toggle seg_n on digit 0 for one cycle at dwell cycle 5 → capture occurs exactly 8 edges after the glitch ends. A 7-cycle dwell captures nothing.
- Invalid glyphs: digit 2 = 8'hFF (blank), digit 1 = 8'h40 ('0' with DP lit) → digit_err=4'b0110, value[11:8]=0, value[7:4]=0, stable=0.
- Illegal enables: an_n = 1100 or 1111 for 20 cycles → no capture and the mask is unchanged. Re-driving a digit already captured in the current frame → its latest value is published.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyphs (active-high, a at bit 0),
// the decimal-point-off level and the capture state encoding.
package seg7_pkg;

  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic DP_OFF = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HELD
  } state_t;

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Inverse glyph lookup: active-high segment pattern to hex nibble.
// hit is low when the pattern is not one of the sixteen hex glyphs.
module seg7_pattern_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPHS[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Multiplexed seven-segment bus monitor: settles each digit, decodes it
// and publishes complete frames with per-digit error flags.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [7:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    valid,
  output logic                    stable,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int KW = IW + 8;
  localparam logic [CNT_W:0] SETTLE_N = (CNT_W+1)'(SETTLE_CYCLES);
  localparam logic [CNT_W:0] ONE_N = (CNT_W+1)'(1);

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W:0] cnt_inc;
  logic [KW-1:0] key, key_q;
  logic active, multi, same, cap, publish;
  logic [IW-1:0] idx;

  logic [3:0] dec_nib, cap_nib;
  logic dec_hit, cap_err;

  logic [NUM_DIGITS-1:0] mask, mask_n;
  logic [NUM_DIGITS-1:0] err_q, err_n;
  logic [4*NUM_DIGITS-1:0] nib_q, nib_n;
  logic prev_bad;

  // Exactly one low enable selects a digit; anything else is blank.
  always_comb begin
    active = 1'b0;
    multi  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) begin
        if (active) multi = 1'b1;
        active = 1'b1;
        idx    = IW'(i);
      end
    end
    if (multi) active = 1'b0;
  end

  assign key  = {idx, seg_n};
  assign same = (key == key_q);
  assign cnt_inc = {1'b0, cnt} + ONE_N;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (!active) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else if (state == S_IDLE || !same) begin
      cnt_n = CNT_W'(1);
      if (SETTLE_N == ONE_N) begin
        cap     = 1'b1;
        state_n = S_HELD;
      end else begin
        state_n = S_SETTLE;
      end
    end else if (state == S_SETTLE) begin
      cnt_n = cnt_inc[CNT_W-1:0];
      if (cnt_inc == SETTLE_N) begin
        cap     = 1'b1;
        state_n = S_HELD;
      end
    end
  end

  seg7_pattern_to_hex u_dec (
    .pattern (~seg_n[6:0]),
    .nibble  (dec_nib),
    .hit     (dec_hit)
  );

  // A lit decimal point or an unknown glyph both read back as 0 with error.
  always_comb begin
    cap_err = !(dec_hit && (seg_n[7] == DP_OFF));
    cap_nib = cap_err ? 4'h0 : dec_nib;
  end

  always_comb begin
    nib_n  = nib_q;
    err_n  = err_q;
    mask_n = mask;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap && idx == IW'(i)) begin
        nib_n[4*i +: 4] = cap_nib;
        err_n[i]        = cap_err;
        mask_n[i]       = 1'b1;
      end
    end
    publish = cap && (&mask_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      key_q     <= '0;
      mask      <= '0;
      nib_q     <= '0;
      err_q     <= '0;
      value     <= '0;
      digit_err <= '0;
      valid     <= 1'b0;
      stable    <= 1'b0;
      prev_bad  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      key_q <= key;
      nib_q <= nib_n;
      err_q <= err_n;
      valid <= publish;
      if (publish) begin
        mask      <= '0;
        value     <= nib_n;
        digit_err <= err_n;
        stable    <= (nib_n == value) && !prev_bad && (err_n == '0);
        prev_bad  <= |err_n;
      end else begin
        mask <= mask_n;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench: a run-length reference model predicts each published
// frame and its edge; a monitor checks every valid pulse against it.
module tb_seg7_scan_capture;

  localparam int N = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] an_n = '1;
  logic [7:0] seg_n = 8'hFF;
  logic [4*N-1:0] value;
  logic valid, stable;
  logic [N-1:0] digit_err;

  seg7_scan_capture #(
    .NUM_DIGITS(N), .SETTLE_CYCLES(S), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n),
    .value(value), .valid(valid), .stable(stable),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int vec = 0;
  int bad = 0;

  task automatic chk(string name, longint act, longint exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Active-low glyph codes as they appear on the bus (DP unlit).
  logic [7:0] glyph_n [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    int          at;
    logic [15:0] val;
    logic [3:0]  err;
    logic        st;
  } exp_t;
  exp_t q[$];

  int          run;
  logic [9:0]  last_key;
  bit          last_act;
  logic [15:0] m_val;
  logic [3:0]  m_err;
  bit          got [N];
  logic [15:0] pub_val;
  bit          pub_bad;

  task automatic model_reset();
    run = 0;
    last_act = 0;
    last_key = '0;
    m_val = '0;
    m_err = '0;
    for (int i = 0; i < N; i++) got[i] = 0;
    pub_val = '0;
    pub_bad = 1;
  endtask

  // Called with the inputs that the next rising edge will see.
  task automatic model_step(logic [N-1:0] an, logic [7:0] seg);
    int nz, d, nib;
    bit act, e, all;
    logic [9:0] key;
    nz = 0;
    d = 0;
    for (int i = 0; i < N; i++)
      if (!an[i]) begin nz++; d = i; end
    act = (nz == 1);
    key = {d[1:0], seg};
    if (!act) run = 0;
    else if (last_act && key == last_key) run++;
    else run = 1;
    if (act && run == S) begin
      nib = 0;
      e = 1;
      for (int k = 0; k < 16; k++)
        if (glyph_n[k] == seg) begin nib = k; e = 0; end
      m_val[4*d +: 4] = 4'(nib);
      m_err[d] = e;
      got[d] = 1;
      all = 1;
      for (int i = 0; i < N; i++) if (!got[i]) all = 0;
      if (all) begin
        q.push_back('{cyc + 1, m_val, m_err,
                      (m_val == pub_val) && !pub_bad && (m_err == 0)});
        pub_val = m_val;
        pub_bad = |m_err;
        for (int i = 0; i < N; i++) got[i] = 0;
      end
    end
    last_key = key;
    last_act = act;
  endtask

  task automatic dwell(logic [N-1:0] an, logic [7:0] seg, int n);
    repeat (n) begin
      @(negedge clk);
      an_n = an;
      seg_n = seg;
      model_step(an, seg);
    end
  endtask

  task automatic frame(logic [7:0] s0, s1, s2, s3);
    dwell(4'b1110, s0, 10);
    dwell(4'b1101, s1, 10);
    dwell(4'b1011, s2, 10);
    dwell(4'b0111, s3, 10);
  endtask

  bit vd = 0;
  always @(negedge clk) begin
    if (rst) begin
      vd = 0;
    end else begin
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("publish_cycle", cyc, e.at);
          chk("value", value, e.val);
          chk("digit_err", digit_err, e.err);
          chk("stable", stable, e.st);
        end
        chk("valid_two_cycles", vd, 0);
      end else if (q.size() > 0 && q[0].at <= cyc) begin
        chk("missing_valid", 0, 1);
        void'(q.pop_front());
      end
      vd = valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_value", value, 0);
    chk("reset_valid", valid, 0);
    chk("reset_stable", stable, 0);
    chk("reset_err", digit_err, 0);
    rst = 1'b0;

    frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    frame(8'h92, 8'hF9, 8'hA4, 8'hB0);
    frame(8'h92, 8'hF9, 8'hA4, 8'hB0);

    // Partial frame then reset mid-dwell; outputs drop asynchronously.
    dwell(4'b1110, 8'h80, 10);
    dwell(4'b1101, 8'h80, 10);
    dwell(4'b1011, 8'h80, 10);
    dwell(4'b0111, 8'h80, 5);
    @(negedge clk);
    rst = 1'b1;
    an_n = '1;
    seg_n = 8'hFF;
    #1;
    chk("async_rst_value", value, 0);
    chk("async_rst_stable", stable, 0);
    chk("async_rst_err", digit_err, 0);
    chk("async_rst_valid", valid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    dwell(4'b0111, 8'h80, 10);
    dwell(4'b1111, 8'hFF, 3);
    frame(8'hC0, 8'hF9, 8'hA4, 8'hB0);

    // Glitch restarts the settle count; a 7-cycle dwell never captures.
    dwell(4'b1110, 8'hC0, 5);
    dwell(4'b1110, 8'hF9, 1);
    dwell(4'b1110, 8'hC0, 10);
    dwell(4'b1101, 8'hF9, 10);
    dwell(4'b1011, 8'hA4, 10);
    dwell(4'b0111, 8'hB0, 10);
    dwell(4'b1110, 8'hF9, 7);
    dwell(4'b1101, 8'h99, 10);
    dwell(4'b1011, 8'h82, 10);
    dwell(4'b0111, 8'hF8, 10);
    dwell(4'b1110, 8'hA4, 10);

    frame(8'hC0, 8'h40, 8'hFF, 8'hB0);

    // Illegal enables mid-frame, then a re-driven digit.
    dwell(4'b1110, 8'hC0, 10);
    dwell(4'b1100, 8'hF9, 20);
    dwell(4'b1111, 8'hF9, 20);
    dwell(4'b1101, 8'hF9, 10);
    dwell(4'b1110, 8'h92, 10);
    dwell(4'b1011, 8'hA4, 10);
    dwell(4'b0111, 8'hB0, 10);

    for (int t = 0; t < 400; t++) begin
      logic [N-1:0] an;
      logic [7:0] seg;
      int n;
      if ($urandom_range(99) < 85) an = ~(4'b1 << $urandom_range(N-1));
      else an = 4'($urandom);
      if ($urandom_range(99) < 80) seg = glyph_n[$urandom_range(15)];
      else seg = 8'($urandom);
      n = $urandom_range(12, 1);
      dwell(an, seg, n);
      if ($urandom_range(99) < 10) dwell(an, seg ^ 8'h01, 1);
    end

    dwell(4'b1111, 8'hFF, 20);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
